// File: rtl/ball_axis_tracker.sv
// ball_axis_tracker
//   One-axis ball position tracker for the Pong datapath. Keeps a binary cell
//   index (and its one-hot decode) over WIDTH cells. It steps once every
//   2^speed qualifying go cycles. At an edge cell the ball either bounces,
//   when the paddle is present, or raises a miss and freezes until re-served.
//
// Ports
//   clocke   in   system clock, rising edge
//   SorR     in   async active-high reset/serve
//   go       in   advance enable; prescaler and stepping only move when high
//   speed    in   [1:0] step period = 2^speed go cycles
//   pad_lo   in   paddle present at cell 0 (sampled on an edge-resolving step)
//   pad_hi   in   paddle present at cell WIDTH-1 (same)
//   pos      out  [WIDTH-1:0] one-hot position
//   pos_idx  out  [IDX_W-1:0] binary position
//   dir      out  1 = toward WIDTH-1, 0 = toward 0
//   running  out  high in RUN
//   bounce   out  one-cycle pulse after a paddle bounce
//   miss_lo  out  one-cycle pulse after a miss at cell 0
//   miss_hi  out  one-cycle pulse after a miss at cell WIDTH-1
module ball_axis_tracker #(
    parameter int WIDTH     = 16,
    parameter int START     = 8,
    parameter bit SERVE_DIR = 1'b1,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clocke,
    input  logic             SorR,
    input  logic             go,
    input  logic [1:0]       speed,
    input  logic             pad_lo,
    input  logic             pad_hi,
    output logic [WIDTH-1:0] pos,
    output logic [IDX_W-1:0] pos_idx,
    output logic             dir,
    output logic             running,
    output logic             bounce,
    output logic             miss_lo,
    output logic             miss_hi
);

    localparam logic [1:0] S_SERVE = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_MISS  = 2'd2;

    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'(START);

    logic [1:0] state;
    logic [2:0] presc;
    logic [2:0] limit;
    logic       step;

    always_comb begin
        limit = 3'd0;
        case (speed)
            2'd0: limit = 3'd0;
            2'd1: limit = 3'd1;
            2'd2: limit = 3'd3;
            default: limit = 3'd7;
        endcase
    end

    // >= rather than == so that lowering speed while the prescaler is
    // already past the new limit steps on the very next go edge.
    assign step = (state == S_RUN) && go && (presc >= limit);

    always_ff @(posedge clocke or posedge SorR) begin
        if (SorR) begin
            state   <= S_SERVE;
            pos_idx <= IDX_START;
            dir     <= SERVE_DIR;
            presc   <= 3'd0;
            bounce  <= 1'b0;
            miss_lo <= 1'b0;
            miss_hi <= 1'b0;
        end else begin
            bounce  <= 1'b0;
            miss_lo <= 1'b0;
            miss_hi <= 1'b0;
            case (state)
                S_SERVE: begin
                    if (go) state <= S_RUN;
                end
                S_RUN: begin
                    if (go) presc <= step ? 3'd0 : presc + 3'd1;
                    if (step) begin
                        if (dir) begin
                            if (pos_idx != IDX_TOP) begin
                                pos_idx <= pos_idx + 1'b1;
                            end else if (pad_hi) begin
                                dir     <= 1'b0;
                                pos_idx <= IDX_TOP - 1'b1;
                                bounce  <= 1'b1;
                            end else begin
                                state   <= S_MISS;
                                miss_hi <= 1'b1;
                            end
                        end else begin
                            if (pos_idx != '0) begin
                                pos_idx <= pos_idx - 1'b1;
                            end else if (pad_lo) begin
                                dir     <= 1'b1;
                                pos_idx <= IDX_W'(1);
                                bounce  <= 1'b1;
                            end else begin
                                state   <= S_MISS;
                                miss_lo <= 1'b1;
                            end
                        end
                    end
                end
                default: ;  // MISS: frozen until SorR
            endcase
        end
    end

    // Decoded from the index so the two can never disagree.
    assign pos     = WIDTH'(1) << pos_idx;
    assign running = (state == S_RUN);

endmodule

// File: tb/tb_ball_axis_tracker.sv
module tb_ball_axis_tracker;

    logic        clocke = 1'b0;
    logic        SorR   = 1'b1;
    logic        go     = 1'b0;
    logic [1:0]  speed  = 2'd0;
    logic        pad_lo = 1'b0;
    logic        pad_hi = 1'b0;

    logic [15:0] pos;
    logic [3:0]  pos_idx;
    logic        dir, running, bounce, miss_lo, miss_hi;

    logic [4:0]  s_pos;
    logic [2:0]  s_idx;
    logic        s_dir, s_running, s_bounce, s_miss_lo, s_miss_hi;

    int checks   = 0;
    int failures = 0;

    always #5 clocke = ~clocke;

    ball_axis_tracker dut (
        .clocke(clocke), .SorR(SorR), .go(go), .speed(speed),
        .pad_lo(pad_lo), .pad_hi(pad_hi), .pos(pos), .pos_idx(pos_idx),
        .dir(dir), .running(running), .bounce(bounce),
        .miss_lo(miss_lo), .miss_hi(miss_hi)
    );

    ball_axis_tracker #(.WIDTH(5), .START(2), .SERVE_DIR(1'b1)) dut_s (
        .clocke(clocke), .SorR(SorR), .go(go), .speed(speed),
        .pad_lo(pad_lo), .pad_hi(pad_hi), .pos(s_pos), .pos_idx(s_idx),
        .dir(s_dir), .running(s_running), .bounce(s_bounce),
        .miss_lo(s_miss_lo), .miss_hi(s_miss_hi)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clocke);
            #1;
        end
    endtask

    // Reset between edges, release, and leave go low.
    task automatic do_reset();
        @(negedge clocke);
        go   = 1'b0;
        SorR = 1'b1;
        #2;
        SorR = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        speed = 2'd0; pad_lo = 1'b0; pad_hi = 1'b0;
        do_reset();
        checks++;
        if (pos !== 16'h0100 || pos_idx !== 4'd8 || dir !== 1'b1 || running !== 1'b0 ||
            bounce !== 1'b0 || miss_lo !== 1'b0 || miss_hi !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pos=%h idx=%0d dir=%b run=%b b=%b ml=%b mh=%b, need 0100 8 1 0 0 0 0",
                     pos, pos_idx, dir, running, bounce, miss_lo, miss_hi);
        end
        go = 1'b1;
        tick(1);
        checks++;
        if (running !== 1'b1 || pos_idx !== 4'd8 || pos !== 16'h0100) begin
            failures++;
            $display("FAIL serve_edge: run=%b idx=%0d pos=%h, need 1 8 0100", running, pos_idx, pos);
        end
        tick(1);
        checks++;
        if (pos_idx !== 4'd9 || pos !== 16'h0200) begin
            failures++;
            $display("FAIL first_step: idx=%0d pos=%h, need 9 0200", pos_idx, pos);
        end
        tick(6);
        checks++;
        if (pos_idx !== 4'd15 || pos !== 16'h8000 || dir !== 1'b1) begin
            failures++;
            $display("FAIL reach_top: idx=%0d pos=%h dir=%b, need 15 8000 1", pos_idx, pos, dir);
        end
    endtask

    task automatic test_bounce();
        pad_hi = 1'b1;
        tick(1);
        checks++;
        if (pos_idx !== 4'd14 || dir !== 1'b0 || bounce !== 1'b1) begin
            failures++;
            $display("FAIL bounce_hi: idx=%0d dir=%b bounce=%b, need 14 0 1", pos_idx, dir, bounce);
        end
        tick(1);
        checks++;
        if (bounce !== 1'b0 || pos_idx !== 4'd13) begin
            failures++;
            $display("FAIL bounce_pulse_width: bounce=%b idx=%0d, need 0 13", bounce, pos_idx);
        end
        pad_hi = 1'b0;
        tick(13);
        checks++;
        if (pos_idx !== 4'd0 || pos !== 16'h0001 || bounce !== 1'b0) begin
            failures++;
            $display("FAIL reach_bottom: idx=%0d pos=%h bounce=%b, need 0 0001 0", pos_idx, pos, bounce);
        end
        pad_lo = 1'b1;
        tick(1);
        checks++;
        if (pos_idx !== 4'd1 || dir !== 1'b1 || bounce !== 1'b1 || miss_lo !== 1'b0) begin
            failures++;
            $display("FAIL bounce_lo: idx=%0d dir=%b bounce=%b ml=%b, need 1 1 1 0", pos_idx, dir, bounce, miss_lo);
        end
        pad_lo = 1'b0;
    endtask

    task automatic test_miss();
        tick(14);
        checks++;
        if (pos_idx !== 4'd15 || running !== 1'b1) begin
            failures++;
            $display("FAIL miss_setup: idx=%0d run=%b, need 15 1", pos_idx, running);
        end
        pad_hi = 1'b0;
        tick(1);
        checks++;
        if (miss_hi !== 1'b1 || running !== 1'b0 || pos_idx !== 4'd15 || miss_lo !== 1'b0) begin
            failures++;
            $display("FAIL miss_hi: mh=%b run=%b idx=%0d ml=%b, need 1 0 15 0", miss_hi, running, pos_idx, miss_lo);
        end
        tick(1);
        checks++;
        if (miss_hi !== 1'b0) begin
            failures++;
            $display("FAIL miss_pulse_width: mh=%b, need 0", miss_hi);
        end
        tick(20);
        checks++;
        if (pos_idx !== 4'd15 || running !== 1'b0 || dir !== 1'b1 || miss_hi !== 1'b0) begin
            failures++;
            $display("FAIL miss_frozen: idx=%0d run=%b dir=%b mh=%b, need 15 0 1 0", pos_idx, running, dir, miss_hi);
        end
        do_reset();
        checks++;
        if (pos_idx !== 4'd8 || dir !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL reserve: idx=%0d dir=%b run=%b, need 8 1 0", pos_idx, dir, running);
        end
    endtask

    task automatic test_prescaler();
        speed = 2'd2;
        do_reset();
        go = 1'b1;
        tick(1);
        tick(3);
        checks++;
        if (pos_idx !== 4'd8) begin
            failures++;
            $display("FAIL presc_hold: idx=%0d, need 8", pos_idx);
        end
        tick(1);
        checks++;
        if (pos_idx !== 4'd9) begin
            failures++;
            $display("FAIL presc_step4: idx=%0d, need 9", pos_idx);
        end
        for (int i = 0; i < 6; i++) begin
            go = (i % 2 == 0);
            tick(1);
        end
        checks++;
        if (pos_idx !== 4'd9) begin
            failures++;
            $display("FAIL presc_toggle_hold: idx=%0d, need 9", pos_idx);
        end
        for (int i = 6; i < 8; i++) begin
            go = (i % 2 == 0);
            tick(1);
        end
        checks++;
        if (pos_idx !== 4'd10) begin
            failures++;
            $display("FAIL presc_toggle_step: idx=%0d, need 10", pos_idx);
        end
    endtask

    task automatic test_gated_go();
        speed = 2'd1;
        do_reset();
        go = 1'b1;
        tick(1);
        tick(1);
        go = 1'b0;
        tick(10);
        checks++;
        if (pos_idx !== 4'd8 || running !== 1'b1) begin
            failures++;
            $display("FAIL gated_hold: idx=%0d run=%b, need 8 1", pos_idx, running);
        end
        go = 1'b1;
        tick(1);
        checks++;
        if (pos_idx !== 4'd9) begin
            failures++;
            $display("FAIL gated_resume: idx=%0d, need 9", pos_idx);
        end
        tick(1);
        checks++;
        if (pos_idx !== 4'd9) begin
            failures++;
            $display("FAIL gated_after: idx=%0d, need 9", pos_idx);
        end
    endtask

    task automatic test_async_reset();
        speed = 2'd0;
        do_reset();
        go = 1'b1;
        tick(1);
        tick(4);
        checks++;
        if (pos_idx !== 4'd12) begin
            failures++;
            $display("FAIL async_setup: idx=%0d, need 12", pos_idx);
        end
        #2;
        SorR = 1'b1;
        #1;
        checks++;
        if (pos !== 16'h0100 || pos_idx !== 4'd8 || running !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pos=%h idx=%0d run=%b, need 0100 8 0", pos, pos_idx, running);
        end
        tick(1);
        checks++;
        if (pos_idx !== 4'd8 || running !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: idx=%0d run=%b, need 8 0", pos_idx, running);
        end
        SorR = 1'b0;
    endtask

    task automatic test_small();
        logic [2:0] exp_idx [11];
        logic       exp_b   [11];
        exp_idx = '{3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
        exp_b   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        speed = 2'd0; pad_lo = 1'b1; pad_hi = 1'b1;
        do_reset();
        checks++;
        if (s_pos !== 5'b00100 || s_idx !== 3'd2) begin
            failures++;
            $display("FAIL small_reset: pos=%b idx=%0d, need 00100 2", s_pos, s_idx);
        end
        go = 1'b1;
        tick(1);
        for (int i = 0; i < 11; i++) begin
            tick(1);
            checks++;
            if (s_idx !== exp_idx[i] || s_bounce !== exp_b[i] ||
                s_pos !== (5'b00001 << exp_idx[i]) || s_running !== 1'b1) begin
                failures++;
                $display("FAIL small_step%0d: idx=%0d pos=%b b=%b run=%b, need %0d %b %b 1",
                         i, s_idx, s_pos, s_bounce, s_running, exp_idx[i],
                         5'b00001 << exp_idx[i], exp_b[i]);
            end
        end
        pad_lo = 1'b0; pad_hi = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_miss();
        test_prescaler();
        test_gated_go();
        test_async_reset();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
